// File: rtl/cpu_pkg.sv
// Shared definitions for the CPU front end: loader state encoding and the NOP word.
package cpu_pkg;

  typedef enum logic [2:0] {
    S_CLEAR,
    S_CNT_HI,
    S_CNT_LO,
    S_DATA_HI,
    S_DATA_LO,
    S_RUN,
    S_ERR
  } loader_state_t;

  localparam logic [15:0] NOP_INSTR = 16'h0000;

endpackage

// File: rtl/imem_ram.sv
// Instruction store: DEPTH x 16 words, one synchronous write port and one
// asynchronous read port for the CPU's same-cycle fetch.
module imem_ram #(
  parameter int DEPTH = 32,
  parameter int AW    = 5
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [15:0]   wdata,
  input  logic [AW-1:0] raddr,
  output logic [15:0]   rdata
);

  logic [15:0] mem [DEPTH];

  // NOTE: storage has no reset; the loader zeroes it word by word after every reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/imem_loader.sv
// Boot loader for the instruction memory: clears it, fills it from a byte
// stream, holds the CPU in reset until the image is in, and serves fetches.
module imem_loader
  import cpu_pkg::*;
#(
  parameter int DEPTH = 32,
  parameter int AW    = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  input  logic        reload,
  input  logic [15:0] pc_addr,
  output logic [15:0] instruction,
  output logic        cpu_rst,
  output logic        load_done,
  output logic        load_error,
  output logic [15:0] words_loaded
);

  loader_state_t state;
  loader_state_t state_next;

  logic [AW-1:0] clr_ptr;
  logic [AW-1:0] wr_ptr;
  logic [15:0]   count;
  logic [7:0]    hi_buf;
  logic          accept;
  logic [15:0]   count_full;

  logic          we;
  logic [AW-1:0] waddr;
  logic [15:0]   wdata;
  logic [15:0]   rdata;

  assign accept     = in_valid && in_ready;
  assign count_full = {count[15:8], in_data};

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    state_next = state;
    case (state)
      S_CLEAR:   if (clr_ptr == AW'(DEPTH - 1)) state_next = S_CNT_HI;
      S_CNT_HI:  if (accept) state_next = S_CNT_LO;
      S_CNT_LO: begin
        if (accept) begin
          if (count_full == 16'd0)             state_next = S_RUN;
          else if (count_full > 16'(DEPTH))    state_next = S_ERR;
          else                                 state_next = S_DATA_HI;
        end
      end
      S_DATA_HI: if (accept) state_next = S_DATA_LO;
      S_DATA_LO: begin
        if (accept) begin
          if (16'(words_loaded + 16'd1) == count) state_next = S_RUN;
          else                                    state_next = S_DATA_HI;
        end
      end
      S_RUN, S_ERR: if (reload) state_next = S_CLEAR;
      default:      state_next = S_CLEAR;
    endcase
  end

  // Status outputs are registered from the next state so they change on the
  // same edge as the state itself.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= S_CLEAR;
      clr_ptr      <= '0;
      wr_ptr       <= '0;
      count        <= '0;
      words_loaded <= '0;
      hi_buf       <= '0;
      in_ready     <= 1'b0;
      cpu_rst      <= 1'b1;
      load_done    <= 1'b0;
      load_error   <= 1'b0;
    end else begin
      state      <= state_next;
      in_ready   <= (state_next inside {S_CNT_HI, S_CNT_LO, S_DATA_HI, S_DATA_LO});
      cpu_rst    <= (state_next != S_RUN);
      load_done  <= (state_next == S_RUN);
      load_error <= (state_next == S_ERR);
      case (state)
        S_CLEAR:   clr_ptr <= clr_ptr + 1'b1;
        S_CNT_HI:  if (accept) count[15:8] <= in_data;
        S_CNT_LO:  if (accept) count[7:0]  <= in_data;
        S_DATA_HI: if (accept) hi_buf      <= in_data;
        S_DATA_LO: begin
          if (accept) begin
            wr_ptr       <= wr_ptr + 1'b1;
            words_loaded <= words_loaded + 16'd1;
          end
        end
        S_RUN, S_ERR: begin
          if (reload) begin
            clr_ptr      <= '0;
            wr_ptr       <= '0;
            count        <= '0;
            words_loaded <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  // Clearing and loading are mutually exclusive states, so one write port suffices.
  assign we    = rst && ((state == S_CLEAR) || ((state == S_DATA_LO) && accept));
  assign waddr = (state == S_CLEAR) ? clr_ptr : wr_ptr;
  assign wdata = (state == S_CLEAR) ? NOP_INSTR : {hi_buf, in_data};

  imem_ram #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk   (clk),
    .we    (we),
    .waddr (waddr),
    .wdata (wdata),
    .raddr (pc_addr[AW-1:0]),
    .rdata (rdata)
  );

  assign instruction = (pc_addr < 16'(DEPTH)) ? rdata : NOP_INSTR;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: expected memory images are queued as
// images are streamed in and drained against the fetch port.
module tb_imem_loader;

  localparam int DEPTH = 32;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        reload;
  logic [15:0] pc_addr;
  logic [15:0] instruction;
  logic        cpu_rst;
  logic        load_done;
  logic        load_error;
  logic [15:0] words_loaded;

  typedef struct {
    logic [15:0] addr;
    logic [15:0] data;
  } exp_t;

  exp_t        exp_q[$];
  logic [15:0] img[$];
  int          vectors     = 0;
  int          miscompares = 0;

  imem_loader #(.DEPTH(32), .AW(5)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_ready     (in_ready),
    .reload       (reload),
    .pc_addr      (pc_addr),
    .instruction  (instruction),
    .cpu_rst      (cpu_rst),
    .load_done    (load_done),
    .load_error   (load_error),
    .words_loaded (words_loaded)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    in_valid = 1'b1;
    in_data  = b;
    while (!in_ready && n < 100) begin
      tick();
      n++;
    end
    if (!in_ready) begin
      vectors++;
      miscompares++;
      $display("FAIL stream_timeout: in_ready=%b after %0d cycles, want 1", in_ready, n);
    end
    tick();
  endtask

  // Expects the DUT to have just entered S_CLEAR; runs through the DEPTH clear cycles.
  task automatic wait_clear(input string tag);
    for (int i = 0; i < DEPTH; i++) begin
      vectors++;
      if (in_ready !== 1'b0 || cpu_rst !== 1'b1) begin
        miscompares++;
        $display("FAIL %s_clear_cycle%0d: in_ready=%b cpu_rst=%b, want 0 1", tag, i, in_ready, cpu_rst);
      end
      tick();
    end
    vectors++;
    if (in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL %s_clear_end: in_ready=%b, want 1", tag, in_ready);
    end
  endtask

  task automatic push_all();
    exp_t e;
    for (int a = 0; a < DEPTH; a++) begin
      e.addr = 16'(a);
      e.data = (a < img.size()) ? img[a] : 16'h0000;
      exp_q.push_back(e);
    end
  endtask

  task automatic check_mem(input string tag);
    exp_t e;
    for (int a = 0; a < DEPTH; a++) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL %s_sb_empty: got empty queue, want entry %0d", tag, a);
      end else begin
        e = exp_q.pop_front();
        pc_addr = e.addr;
        #1;
        if (instruction !== e.data) begin
          miscompares++;
          $display("FAIL %s_mem[%0d]: got %h, want %h", tag, e.addr, instruction, e.data);
        end
      end
    end
  endtask

  task automatic gap(input bit bp);
    if (bp) begin
      in_valid = 1'b0;
      tick();
    end
  endtask

  // Streams the count for img plus the first n_send words; bp adds stalls.
  task automatic load_image(input int n_send, input bit bp, input string tag);
    logic [15:0] c;
    logic [15:0] w;
    logic [15:0] wl;
    c = 16'(img.size());
    send_byte(c[15:8]);
    gap(bp);
    send_byte(c[7:0]);
    for (int i = 0; i < n_send; i++) begin
      w = img[i];
      gap(bp);
      send_byte(w[15:8]);
      if (bp) begin
        in_valid = 1'b0;
        wl = words_loaded;
        repeat (10) tick();
        vectors++;
        if (in_ready !== 1'b1 || words_loaded !== wl || cpu_rst !== 1'b1) begin
          miscompares++;
          $display("FAIL %s_stall%0d: in_ready=%b words=%0d cpu_rst=%b, want 1 %0d 1",
                   tag, i, in_ready, words_loaded, cpu_rst, wl);
        end
      end
      gap(bp);
      if (i == img.size() - 1) begin
        vectors++;
        if (cpu_rst !== 1'b1) begin
          miscompares++;
          $display("FAIL %s_cpu_rst_before_last: got %b, want 1", tag, cpu_rst);
        end
      end
      send_byte(w[7:0]);
      if (i == img.size() - 1) begin
        vectors++;
        if (cpu_rst !== 1'b0 || load_done !== 1'b1 || words_loaded !== c) begin
          miscompares++;
          $display("FAIL %s_done: cpu_rst=%b load_done=%b words=%0d, want 0 1 %0d",
                   tag, cpu_rst, load_done, words_loaded, c);
        end
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic pulse_reload();
    reload = 1'b1;
    tick();
    reload = 1'b0;
  endtask

  task automatic set_boot_image();
    img = {16'h0400, 16'h0801, 16'h4053, 16'h2582, 16'h0902};
  endtask

  task automatic test_reset();
    rst = 1'b0;
    tick();
    tick();
    vectors++;
    if (in_ready !== 1'b0 || cpu_rst !== 1'b1 || load_done !== 1'b0 ||
        load_error !== 1'b0 || words_loaded !== 16'd0) begin
      miscompares++;
      $display("FAIL reset_outputs: ready=%b cpu_rst=%b done=%b err=%b words=%0d, want 0 1 0 0 0",
               in_ready, cpu_rst, load_done, load_error, words_loaded);
    end
    rst = 1'b1;
    wait_clear("reset");
    img.delete();
    push_all();
    check_mem("reset");
  endtask

  // Fills every word with 0xFFFF (count == DEPTH boundary), then checks a reset zeroes it.
  task automatic test_full_image();
    img.delete();
    for (int i = 0; i < DEPTH; i++) img.push_back(16'hFFFF);
    load_image(DEPTH, 1'b0, "full");
    push_all();
    check_mem("full");
    pc_addr = 16'd32;
    #1;
    vectors++;
    if (instruction !== 16'h0000) begin
      miscompares++;
      $display("FAIL full_pc32: got %h, want 0000", instruction);
    end
    rst = 1'b0;
    tick();
    rst = 1'b1;
    wait_clear("rezero");
    img.delete();
    push_all();
    check_mem("rezero");
  endtask

  task automatic test_boot();
    set_boot_image();
    load_image(5, 1'b0, "boot");
    pc_addr = 16'd2;
    #1;
    vectors++;
    if (instruction !== 16'h4053) begin
      miscompares++;
      $display("FAIL boot_pc2: got %h, want 4053", instruction);
    end
    pc_addr = 16'd40;
    #1;
    vectors++;
    if (instruction !== 16'h0000) begin
      miscompares++;
      $display("FAIL boot_pc40: got %h, want 0000", instruction);
    end
    push_all();
    check_mem("boot");
  endtask

  task automatic test_run_stall_and_reload();
    in_valid = 1'b1;
    in_data  = 8'hAA;
    repeat (5) tick();
    vectors++;
    if (in_ready !== 1'b0 || words_loaded !== 16'd5 || load_done !== 1'b1) begin
      miscompares++;
      $display("FAIL run_ignore: ready=%b words=%0d done=%b, want 0 5 1", in_ready, words_loaded, load_done);
    end
    in_valid = 1'b0;
    pulse_reload();
    vectors++;
    if (cpu_rst !== 1'b1 || load_done !== 1'b0 || words_loaded !== 16'd0) begin
      miscompares++;
      $display("FAIL run_reload: cpu_rst=%b done=%b words=%0d, want 1 0 0", cpu_rst, load_done, words_loaded);
    end
    wait_clear("run_reload");
  endtask

  task automatic test_backpressure();
    set_boot_image();
    load_image(5, 1'b1, "bp");
    push_all();
    check_mem("bp");
    pulse_reload();
    wait_clear("bp_reload");
  endtask

  task automatic test_oversize();
    pulse_reload();
    vectors++;
    if (in_ready !== 1'b1 || cpu_rst !== 1'b1) begin
      miscompares++;
      $display("FAIL reload_ignored: ready=%b cpu_rst=%b, want 1 1", in_ready, cpu_rst);
    end
    send_byte(8'h00);
    send_byte(8'h21);
    in_valid = 1'b0;
    vectors++;
    if (load_error !== 1'b1 || in_ready !== 1'b0 || cpu_rst !== 1'b1 || load_done !== 1'b0) begin
      miscompares++;
      $display("FAIL oversize_err: err=%b ready=%b cpu_rst=%b done=%b, want 1 0 1 0",
               load_error, in_ready, cpu_rst, load_done);
    end
    pulse_reload();
    vectors++;
    if (load_error !== 1'b0) begin
      miscompares++;
      $display("FAIL oversize_reload_err: got %b, want 0", load_error);
    end
    wait_clear("oversize");
  endtask

  task automatic test_zero_count();
    send_byte(8'h00);
    send_byte(8'h00);
    in_valid = 1'b0;
    vectors++;
    if (cpu_rst !== 1'b0 || load_done !== 1'b1 || words_loaded !== 16'd0) begin
      miscompares++;
      $display("FAIL zero_run: cpu_rst=%b done=%b words=%0d, want 0 1 0", cpu_rst, load_done, words_loaded);
    end
    img.delete();
    push_all();
    check_mem("zero");
    pulse_reload();
    wait_clear("zero_reload");
  endtask

  task automatic test_mid_load_and_reload();
    set_boot_image();
    load_image(3, 1'b0, "mid");
    vectors++;
    if (words_loaded !== 16'd3 || cpu_rst !== 1'b1) begin
      miscompares++;
      $display("FAIL mid_partial: words=%0d cpu_rst=%b, want 3 1", words_loaded, cpu_rst);
    end
    rst = 1'b0;
    tick();
    rst = 1'b1;
    vectors++;
    if (words_loaded !== 16'd0 || cpu_rst !== 1'b1) begin
      miscompares++;
      $display("FAIL mid_abort: words=%0d cpu_rst=%b, want 0 1", words_loaded, cpu_rst);
    end
    wait_clear("mid");
    img = {16'h1234};
    load_image(1, 1'b0, "one");
    push_all();
    check_mem("one");
    pulse_reload();
    vectors++;
    if (cpu_rst !== 1'b1) begin
      miscompares++;
      $display("FAIL final_reload_cpu_rst: got %b, want 1", cpu_rst);
    end
    wait_clear("final");
    img.delete();
    push_all();
    check_mem("final");
  endtask

  initial begin
    rst      = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    reload   = 1'b0;
    pc_addr  = 16'h0000;
    #1;
    test_reset();
    test_full_image();
    test_boot();
    test_run_stall_and_reload();
    test_backpressure();
    test_oversize();
    test_zero_count();
    test_mid_load_and_reload();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
